converter_bin_to_c2_seq: RTL

- Sequential sign-magnitude to two's-complement converter for the MDR datapath; the inverse of the existing c2-to-binary conversion.
- Takes the sign and magnitude produced by the sequential multiplier/divider core and returns the result on the two's-complement data bus.
- Works bit-serially, LSB first: copy bits up to and including the first 1, invert every later bit when the sign is set. Uses a start/busy/done handshake.

---
 rtl/mdr_pkg.sv | 20 ++
 rtl/converter_bin_to_c2_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mdr_pkg.sv
// Shared definitions for the MDR (multiplier/divider) datapath.
//   DW_MDR         : datapath width in bits
//   data_bus_n     : DW_MDR-wide data bus type
//   c2conv_state_e : control states of the sign-magnitude to two's-complement converter
//   c2conv_cnt_t   : bit counter type for the serial converter
package mdr_pkg;

  localparam int unsigned DW_MDR = 8;

  typedef logic [DW_MDR-1:0] data_bus_n;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } c2conv_state_e;

  typedef logic [$clog2(DW_MDR)-1:0] c2conv_cnt_t;

endpackage

// File: rtl/converter_bin_to_c2_seq.sv
// Bit-serial sign-magnitude to two's-complement converter, LSB first.
// Bits up to and including the first 1 are copied; when the operand is
// negative every later bit is inverted.
//   clk         : clock, rising edge
//   rst         : synchronous reset, active high
//   start       : request conversion (sampled only while idle)
//   sign        : operand sign, 1 = negative (sampled with start)
//   binary      : operand magnitude (sampled with start)
//   complement2 : registered two's-complement result
//   done        : one-cycle pulse when complement2/overflow were just updated
//   busy        : high while a conversion is in progress
//   overflow    : registered; magnitude not representable for the sign
module converter_bin_to_c2_seq
  import mdr_pkg::*;
#(
  parameter int unsigned DW = DW_MDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sign,
  input  logic [DW-1:0] binary,
  output logic [DW-1:0] complement2,
  output logic          done,
  output logic          busy,
  output logic          overflow
);

  localparam int unsigned    CW   = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DW - 1);

  c2conv_state_e state_q, state_d;

  logic [DW-1:0] sreg_q, sreg_d;
  logic [DW-1:0] res_q,  res_d;
  logic [DW-1:0] c2_q,   c2_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic          sign_q, sign_d;
  logic          seen_q, seen_d;
  logic          ovfn_q, ovfn_d;
  logic          ovf_q,  ovf_d;

  logic          in_bit;
  logic          out_bit;
  logic [DW-1:0] res_shift;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      res_q   <= '0;
      c2_q    <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
      ovfn_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      res_q   <= res_d;
      c2_q    <= c2_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      seen_q  <= seen_d;
      ovfn_q  <= ovfn_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Serial datapath
  assign in_bit    = sreg_q[0];
  assign out_bit   = (sign_q & seen_q) ? ~in_bit : in_bit;
  assign res_shift = {out_bit, res_q[DW-1:1]};

  always_comb begin
    sreg_d = sreg_q;
    res_d  = res_q;
    c2_d   = c2_q;
    cnt_d  = cnt_q;
    sign_d = sign_q;
    seen_d = seen_q;
    ovfn_d = ovfn_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d = binary;
          sign_d = sign;
          res_d  = '0;
          cnt_d  = '0;
          seen_d = 1'b0;
          // Positive needs MSB clear; negative allows up to exactly 2^(DW-1).
          ovfn_d = sign ? (binary[DW-1] & (|binary[DW-2:0])) : binary[DW-1];
        end
      end
      SHIFT: begin
        sreg_d = sreg_q >> 1;
        seen_d = seen_q | in_bit;
        res_d  = res_shift;
        cnt_d  = cnt_q + 1'b1;
        // The final bit is folded in directly so the result lands on the
        // same edge that enters DONE.
        if (cnt_q == LAST) begin
          c2_d  = res_shift;
          ovf_d = ovfn_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign complement2 = c2_q;
  assign overflow    = ovf_q;

endmodule
